// File: rtl/multibyte_add_sequencer_if.sv
// Operand and result handshake bundle for the serial multi-byte adder.
// The master issues operands and consumes results; the slave is the adder.
interface multibyte_add_sequencer_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/multibyte_add_sequencer.sv
// Serial multi-precision add/subtract: one 8-bit slice reused per clock,
// with the inter-byte carry held in a flop between passes.
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  multibyte_add_sequencer_if.slave     bus,
  output logic                         busy
);
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_reg;
  logic [NBYTES-1:0][7:0]  a_reg;
  logic [NBYTES-1:0][7:0]  b_reg;
  logic [NBYTES-1:0][7:0]  sum_reg;
  logic [CW-1:0]           count_reg;
  logic                    carry_reg;
  logic                    c_out_reg;
  logic                    ovf_reg;

  logic [7:0]              a_byte;
  logic [7:0]              b_byte;
  logic [8:0]              slice;
  logic                    carry_into_msb;
  logic                    last_byte;

  // Byte select written as a compare-mux so every NBYTES (including 1) is width-clean.
  always_comb begin
    a_byte = 8'd0;
    b_byte = 8'd0;
    for (int i = 0; i < NBYTES; i++) begin
      if (count_reg == CW'(i)) begin
        a_byte = a_reg[i];
        b_byte = b_reg[i];
      end
    end
    slice          = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_reg};
    carry_into_msb = a_byte[7] ^ b_byte[7] ^ slice[7];
    last_byte      = (count_reg == CW'(NBYTES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      count_reg <= '0;
      carry_reg <= 1'b0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
            a_reg     <= bus.a;
            b_reg     <= bus.sub ? ~bus.b : bus.b;
            count_reg <= '0;
            carry_reg <= bus.sub;
            state_reg <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (count_reg == CW'(i)) begin
              sum_reg[i] <= slice[7:0];
            end
          end
          carry_reg <= slice[8];
          if (last_byte) begin
            c_out_reg <= slice[8];
            ovf_reg   <= carry_into_msb ^ slice[8];
            state_reg <= DONE;
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.sum       = sum_reg;
  assign bus.c_out     = c_out_reg;
  assign bus.ovf       = ovf_reg;
  assign busy          = (state_reg != IDLE);
endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Directed bench: vector table on a 4-byte adder, hand sequences for
// backpressure and mid-operation reset, plus a 1-byte build.
module tb_multibyte_add_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy4;
  logic busy1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multibyte_add_sequencer_if #(.NBYTES(4)) if4 ();
  multibyte_add_sequencer_if #(.NBYTES(1)) if1 ();

  multibyte_add_sequencer #(.NBYTES(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave),
    .busy  (busy4)
  );

  multibyte_add_sequencer #(.NBYTES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave),
    .busy  (busy1)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp_sum;
    logic        exp_c;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for out_valid on the 4-byte DUT; returns edges since accept.
  task automatic wait_done4(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      lat = i;
      if (if4.out_valid) break;
    end
    if (!if4.out_valid) lat = 99;
  endtask

  task automatic run_vec(input int idx);
    int lat;
    vec_t v;
    v = vecs[idx];
    check("in_ready_idle", 64'(if4.in_ready), 64'd1);
    if4.a = v.a; if4.b = v.b; if4.sub = v.sub;
    if4.in_valid = 1'b1; if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    if4.a = '1; if4.b = '1; if4.sub = ~v.sub;
    wait_done4(lat);
    check("latency", 64'(lat), 64'd4);
    check("sum", 64'(if4.sum), 64'(v.exp_sum));
    check("c_out", 64'(if4.c_out), 64'(v.exp_c));
    check("ovf", 64'(if4.ovf), 64'(v.exp_ovf));
    @(posedge clk); #1;
    check("out_valid_one_cycle", 64'(if4.out_valid), 64'd0);
    $display("vec %0d: a=%08h b=%08h sub=%0d -> sum=%08h c=%0d ovf=%0d lat=%0d",
             idx, v.a, v.b, v.sub, if4.sum, if4.c_out, if4.ovf, lat);
  endtask

  initial begin
    int lat;
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[6] = '{32'h00000010, 32'h00000010, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};

    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.sub = 1'b0; if4.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.sub = 1'b0; if1.out_ready = 1'b0;

    #12;
    check("rst_in_ready", 64'(if4.in_ready), 64'd1);
    check("rst_out_valid", 64'(if4.out_valid), 64'd0);
    check("rst_sum", 64'(if4.sum), 64'd0);
    check("rst_busy", 64'(busy4), 64'd0);
    $display("reset: in_ready=%0d out_valid=%0d sum=%08h busy=%0d",
             if4.in_ready, if4.out_valid, if4.sum, busy4);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Backpressure: hold result for 3 cycles while new operands wait.
    if4.a = 32'h00000001; if4.b = 32'h00000002; if4.sub = 1'b0;
    if4.in_valid = 1'b1; if4.out_ready = 1'b0;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    wait_done4(lat);
    check("bp_latency", 64'(lat), 64'd4);
    if4.a = 32'h00000010; if4.b = 32'h00000020; if4.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(if4.out_valid), 64'd1);
      check("bp_sum_held", 64'(if4.sum), 64'h3);
      check("bp_flags_held", 64'({if4.c_out, if4.ovf}), 64'd0);
      check("bp_in_ready", 64'(if4.in_ready), 64'd0);
    end
    $display("backpressure: held sum=%08h out_valid=%0d in_ready=%0d", if4.sum, if4.out_valid, if4.in_ready);
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_gap_valid", 64'(if4.out_valid), 64'd0);
    check("bp_idle_gap_ready", 64'(if4.in_ready), 64'd1);
    @(posedge clk); #1;
    check("bp_accept_busy", 64'(busy4), 64'd1);
    if4.in_valid = 1'b0;
    wait_done4(lat);
    check("bp2_latency", 64'(lat), 64'd4);
    check("bp2_sum", 64'(if4.sum), 64'h30);
    $display("backpressure next op: sum=%08h lat=%0d", if4.sum, lat);
    @(posedge clk); #1;

    // Reset with count=2 and a pending carry of 1.
    if4.a = 32'hFFFFFFFF; if4.b = 32'h00000001; if4.sub = 1'b0; if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", 64'(if4.sum), 64'd0);
    check("mid_rst_out_valid", 64'(if4.out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(if4.in_ready), 64'd1);
    check("mid_rst_busy", 64'(busy4), 64'd0);
    check("mid_rst_flags", 64'({if4.c_out, if4.ovf}), 64'd0);
    $display("mid reset: sum=%08h in_ready=%0d busy=%0d", if4.sum, if4.in_ready, busy4);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    if4.a = 32'h00010000; if4.b = 32'h0000FFFF; if4.sub = 1'b0; if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    wait_done4(lat);
    check("post_rst_latency", 64'(lat), 64'd4);
    check("post_rst_sum", 64'(if4.sum), 64'h0001FFFF);
    check("post_rst_c_out", 64'(if4.c_out), 64'd0);
    $display("after reset op: sum=%08h c=%0d lat=%0d", if4.sum, if4.c_out, lat);
    @(posedge clk); #1;

    // Single-byte build: one RUN cycle.
    if1.a = 8'h80; if1.b = 8'h80; if1.sub = 1'b0; if1.out_ready = 1'b1; if1.in_valid = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (if1.out_valid) begin
        lat = i;
        break;
      end
    end
    check("nb1_latency", 64'(lat), 64'd1);
    check("nb1_sum", 64'(if1.sum), 64'h00);
    check("nb1_c_out", 64'(if1.c_out), 64'd1);
    check("nb1_ovf", 64'(if1.ovf), 64'd1);
    $display("nbytes1: sum=%02h c=%0d ovf=%0d lat=%0d", if1.sum, if1.c_out, if1.ovf, lat);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
